// File: rtl/ram_tdp_masked_if.sv
// Bus bundle for the two access ports of ram_tdp_masked.
// The requesting agent uses the master view, the RAM uses the slave view.
interface ram_tdp_masked_if #(
    parameter int AddrWidth = 12,
    parameter int DataWidth = 8
);
    // Port A request and response
    logic                 cenA;
    logic                 wenA;
    logic [AddrWidth-1:0] aA;
    logic [DataWidth-1:0] dA;
    logic [DataWidth-1:0] bwA;
    logic [DataWidth-1:0] qA;
    logic                 qA_valid;

    // Port B request and response
    logic                 cenB;
    logic                 wenB;
    logic [AddrWidth-1:0] aB;
    logic [DataWidth-1:0] dB;
    logic [DataWidth-1:0] bwB;
    logic [DataWidth-1:0] qB;
    logic                 qB_valid;

    modport master (
        output cenA, wenA, aA, dA, bwA,
        output cenB, wenB, aB, dB, bwB,
        input  qA, qA_valid,
        input  qB, qB_valid
    );

    modport slave (
        input  cenA, wenA, aA, dA, bwA,
        input  cenB, wenB, aB, dB, bwB,
        output qA, qA_valid,
        output qB, qB_valid
    );
endinterface

// File: rtl/ram_tdp_masked.sv
// Single-clock true dual-port RAM with per-bit write masks.
// Same-address collisions resolve deterministically (read-during-write mode
// and write priority are parameters) and are tallied in a saturating counter.
// Optional second output register trades one cycle of latency for timing.
module ram_tdp_masked #(
    parameter int AddrWidth  = 12,
    parameter int DataWidth  = 8,
    parameter int Pipelined  = 0,
    parameter int WriteFirst = 0,
    parameter int PrioA      = 1,
    parameter int CntWidth   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_tdp_masked_if.slave     bus,
    input  logic                clr_cnt,
    output logic [CntWidth-1:0] coll_cnt,
    output logic                coll_flag
);

    localparam int Depth = 2 ** AddrWidth;

    // Storage array; deliberately never reset.
    logic [DataWidth-1:0] mem [Depth];

    // Masked merge of write data into an existing word.
    function automatic logic [DataWidth-1:0] merge_word(
        input logic [DataWidth-1:0] old_w,
        input logic [DataWidth-1:0] d,
        input logic [DataWidth-1:0] bw
    );
        return (old_w & ~bw) | (d & bw);
    endfunction

    // Two writers on one word: the winner's mask takes every bit it covers,
    // the loser only lands on bits the winner left untouched.
    function automatic logic [DataWidth-1:0] merge_pair(
        input logic [DataWidth-1:0] old_w,
        input logic [DataWidth-1:0] d_win,
        input logic [DataWidth-1:0] bw_win,
        input logic [DataWidth-1:0] d_lose,
        input logic [DataWidth-1:0] bw_lose
    );
        return (old_w & ~bw_win & ~bw_lose)
             | (d_lose & bw_lose & ~bw_win)
             | (d_win & bw_win);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CntWidth-1:0] sat_inc(
        input logic [CntWidth-1:0] v
    );
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    // Writes are held off until the first edge after reset release has
    // passed, so a write sampled on that edge never reaches the array.
    logic armed;

    logic                 rdA_p0, rdB_p0;
    logic                 wrA_p0, wrB_p0;
    logic                 same_p0;
    logic                 ww_p0;
    logic                 coll_p0;
    logic [DataWidth-1:0] oldA_p0, oldB_p0;
    logic [DataWidth-1:0] wordA_p0, wordB_p0;
    logic [DataWidth-1:0] wwword_p0;
    logic [DataWidth-1:0] rdataA_p0, rdataB_p0;

    logic [DataWidth-1:0] qA_p1, qB_p1;
    logic                 vldA_p1, vldB_p1;

    // Arm the write path one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // ---- stage p0: request decode, collision detect, read data select ----
    // Decode both ports and resolve same-address interactions.
    always_comb begin
        rdA_p0    = 1'b0;
        rdB_p0    = 1'b0;
        wrA_p0    = 1'b0;
        wrB_p0    = 1'b0;
        same_p0   = 1'b0;
        ww_p0     = 1'b0;
        coll_p0   = 1'b0;
        oldA_p0   = '0;
        oldB_p0   = '0;
        wordA_p0  = '0;
        wordB_p0  = '0;
        wwword_p0 = '0;
        rdataA_p0 = '0;
        rdataB_p0 = '0;

        rdA_p0  = !bus.cenA && bus.wenA;
        rdB_p0  = !bus.cenB && bus.wenB;
        wrA_p0  = !bus.cenA && !bus.wenA && armed;
        wrB_p0  = !bus.cenB && !bus.wenB && armed;
        same_p0 = (bus.aA == bus.aB);

        oldA_p0  = mem[bus.aA];
        oldB_p0  = mem[bus.aB];
        wordA_p0 = merge_word(oldA_p0, bus.dA, bus.bwA);
        wordB_p0 = merge_word(oldB_p0, bus.dB, bus.bwB);

        ww_p0 = wrA_p0 && wrB_p0 && same_p0;
        if (PrioA != 0) begin
            wwword_p0 = merge_pair(oldA_p0, bus.dA, bus.bwA, bus.dB, bus.bwB);
        end else begin
            wwword_p0 = merge_pair(oldA_p0, bus.dB, bus.bwB, bus.dA, bus.bwA);
        end

        // Read/read on one address is harmless; any write involvement counts.
        coll_p0 = same_p0 && ((rdA_p0 && wrB_p0) ||
                              (wrA_p0 && rdB_p0) ||
                              (wrA_p0 && wrB_p0));

        // Cross-port bypass returns exactly the word that will be stored.
        rdataA_p0 = oldA_p0;
        rdataB_p0 = oldB_p0;
        if (WriteFirst != 0) begin
            if (rdA_p0 && wrB_p0 && same_p0) begin
                rdataA_p0 = wordB_p0;
            end
            if (rdB_p0 && wrA_p0 && same_p0) begin
                rdataB_p0 = wordA_p0;
            end
        end
    end

    // Commit writes; a same-address double write collapses to one merged word.
    always_ff @(posedge clk) begin
        if (ww_p0) begin
            mem[bus.aA] <= wwword_p0;
        end else begin
            if (wrA_p0) begin
                mem[bus.aA] <= wordA_p0;
            end
            if (wrB_p0) begin
                mem[bus.aB] <= wordB_p0;
            end
        end
    end

    // ---- stage p1: first output register, data held when no read ----
    // Capture read data and raise a one-cycle valid per completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qA_p1   <= '0;
            qB_p1   <= '0;
            vldA_p1 <= 1'b0;
            vldB_p1 <= 1'b0;
        end else begin
            vldA_p1 <= rdA_p0;
            vldB_p1 <= rdB_p0;
            if (rdA_p0) begin
                qA_p1 <= rdataA_p0;
            end
            if (rdB_p0) begin
                qB_p1 <= rdataB_p0;
            end
        end
    end

    // ---- stage p2: optional second output register ----
    generate
        if (Pipelined != 0) begin : g_out_p2
            logic [DataWidth-1:0] qA_p2, qB_p2;
            logic                 vldA_p2, vldB_p2;

            // Delay data and valid together by one more cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qA_p2   <= '0;
                    qB_p2   <= '0;
                    vldA_p2 <= 1'b0;
                    vldB_p2 <= 1'b0;
                end else begin
                    vldA_p2 <= vldA_p1;
                    vldB_p2 <= vldB_p1;
                    if (vldA_p1) begin
                        qA_p2 <= qA_p1;
                    end
                    if (vldB_p1) begin
                        qB_p2 <= qB_p1;
                    end
                end
            end

            assign bus.qA       = qA_p2;
            assign bus.qB       = qB_p2;
            assign bus.qA_valid = vldA_p2;
            assign bus.qB_valid = vldB_p2;
        end else begin : g_out_p1
            assign bus.qA       = qA_p1;
            assign bus.qB       = qB_p1;
            assign bus.qA_valid = vldA_p1;
            assign bus.qB_valid = vldB_p1;
        end
    endgenerate

    // Debug tally of collision cycles; clear beats a simultaneous collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt  <= '0;
            coll_flag <= 1'b0;
        end else if (clr_cnt) begin
            coll_cnt  <= '0;
            coll_flag <= 1'b0;
        end else if (coll_p0) begin
            coll_cnt  <= sat_inc(coll_cnt);
            coll_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_tdp_masked.sv
// Directed bench for ram_tdp_masked. Two instances share one stimulus:
// dut0 = latency 1, read-first, port A priority, 8-bit counter;
// dut1 = latency 2, write-first, port B priority, 2-bit counter.
module tb_ram_tdp_masked;

    logic        clk;
    logic        rst_n;
    logic        clr_cnt;

    logic        cenA, wenA, cenB, wenB;
    logic [11:0] aA, aB;
    logic [7:0]  dA, bwA, dB, bwB;

    logic [7:0]  cnt0;
    logic        flag0;
    logic [1:0]  cnt1;
    logic        flag1;

    int          checks;
    int          errors;

    ram_tdp_masked_if #(.AddrWidth(12), .DataWidth(8)) if0 ();
    ram_tdp_masked_if #(.AddrWidth(12), .DataWidth(8)) if1 ();

    assign if0.cenA = cenA;  assign if1.cenA = cenA;
    assign if0.wenA = wenA;  assign if1.wenA = wenA;
    assign if0.aA   = aA;    assign if1.aA   = aA;
    assign if0.dA   = dA;    assign if1.dA   = dA;
    assign if0.bwA  = bwA;   assign if1.bwA  = bwA;
    assign if0.cenB = cenB;  assign if1.cenB = cenB;
    assign if0.wenB = wenB;  assign if1.wenB = wenB;
    assign if0.aB   = aB;    assign if1.aB   = aB;
    assign if0.dB   = dB;    assign if1.dB   = dB;
    assign if0.bwB  = bwB;   assign if1.bwB  = bwB;

    ram_tdp_masked #(
        .AddrWidth(12), .DataWidth(8), .Pipelined(0),
        .WriteFirst(0), .PrioA(1), .CntWidth(8)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0),
        .clr_cnt(clr_cnt), .coll_cnt(cnt0), .coll_flag(flag0)
    );

    ram_tdp_masked #(
        .AddrWidth(12), .DataWidth(8), .Pipelined(1),
        .WriteFirst(1), .PrioA(0), .CntWidth(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .clr_cnt(clr_cnt), .coll_cnt(cnt1), .coll_flag(flag1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setA(input logic cen, input logic wen, input logic [11:0] a,
                        input logic [7:0] d, input logic [7:0] bw);
        cenA = cen; wenA = wen; aA = a; dA = d; bwA = bw;
    endtask

    task automatic setB(input logic cen, input logic wen, input logic [11:0] a,
                        input logic [7:0] d, input logic [7:0] bw);
        cenB = cen; wenB = wen; aB = a; dB = d; bwB = bw;
    endtask

    task automatic idle_all();
        setA(1'b1, 1'b1, 12'h000, 8'h00, 8'h00);
        setB(1'b1, 1'b1, 12'h000, 8'h00, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        clr_cnt = 1'b0;
        idle_all();

        // Reset state
        #12;
        chk("rst_qA0", if0.qA, 8'h00);
        chk("rst_vA0", if0.qA_valid, 1'b0);
        chk("rst_qB1", if1.qB, 8'h00);
        chk("rst_vB1", if1.qB_valid, 1'b0);
        chk("rst_cnt0", cnt0, 8'd0);
        chk("rst_flag1", flag1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Basic write A, read B
        setA(1'b0, 1'b0, 12'h010, 8'h5A, 8'hFF);
        tick();
        setA(1'b1, 1'b1, 12'h000, 8'h00, 8'h00);
        setB(1'b0, 1'b1, 12'h010, 8'h00, 8'h00);
        tick();
        chk("basic_qB0", if0.qB, 8'h5A);
        chk("basic_vB0", if0.qB_valid, 1'b1);
        chk("basic_vB1_early", if1.qB_valid, 1'b0);
        idle_all();
        tick();
        chk("basic_vB0_drop", if0.qB_valid, 1'b0);
        chk("basic_qB0_hold", if0.qB, 8'h5A);
        chk("basic_qB1", if1.qB, 8'h5A);
        chk("basic_vB1", if1.qB_valid, 1'b1);
        chk("basic_cnt0", cnt0, 8'd0);
        chk("basic_cnt1", cnt1, 2'd0);

        // Masked write: F0 then d=0F bw=3C -> CC
        setA(1'b0, 1'b0, 12'h020, 8'hF0, 8'hFF);
        tick();
        setA(1'b0, 1'b0, 12'h020, 8'h0F, 8'h3C);
        tick();
        chk("mask_wr_v0", if0.qA_valid, 1'b0);
        setA(1'b0, 1'b1, 12'h020, 8'h00, 8'h00);
        tick();
        chk("mask_qA0", if0.qA, 8'hCC);
        chk("mask_vA0", if0.qA_valid, 1'b1);
        idle_all();
        tick();
        chk("mask_qA1", if1.qA, 8'hCC);
        chk("mask_vA1", if1.qA_valid, 1'b1);

        // Cross-port read-during-write at 0x030
        setA(1'b0, 1'b0, 12'h030, 8'h11, 8'hFF);
        tick();
        setA(1'b0, 1'b0, 12'h030, 8'h22, 8'hFF);
        setB(1'b0, 1'b1, 12'h030, 8'h00, 8'h00);
        tick();
        chk("rdw_qB0_old", if0.qB, 8'h11);
        chk("rdw_vB0", if0.qB_valid, 1'b1);
        chk("rdw_cnt0", cnt0, 8'd1);
        chk("rdw_flag0", flag0, 1'b1);
        chk("rdw_cnt1", cnt1, 2'd1);
        chk("rdw_flag1", flag1, 1'b1);
        idle_all();
        tick();
        chk("rdw_qB1_new", if1.qB, 8'h22);
        chk("rdw_vB1", if1.qB_valid, 1'b1);
        setB(1'b0, 1'b1, 12'h030, 8'h00, 8'h00);
        tick();
        chk("rdw_after_qB0", if0.qB, 8'h22);
        idle_all();
        tick();
        chk("rdw_after_qB1", if1.qB, 8'h22);
        chk("rdw_after_vB1", if1.qB_valid, 1'b1);

        // Write/write collision at 0x040
        setA(1'b0, 1'b0, 12'h040, 8'h00, 8'hFF);
        tick();
        setA(1'b0, 1'b0, 12'h040, 8'hAA, 8'hF0);
        setB(1'b0, 1'b0, 12'h040, 8'h55, 8'hFF);
        tick();
        chk("ww_cnt0", cnt0, 8'd2);
        chk("ww_cnt1", cnt1, 2'd2);
        setA(1'b1, 1'b1, 12'h000, 8'h00, 8'h00);
        setB(1'b0, 1'b1, 12'h040, 8'h00, 8'h00);
        tick();
        chk("ww_prioA_qB0", if0.qB, 8'hA5);
        idle_all();
        tick();
        chk("ww_prioB_qB1", if1.qB, 8'h55);

        // Streaming reads of addresses 0..3 plus a reference word at 0x060
        for (int i = 0; i < 4; i++) begin
            setA(1'b0, 1'b0, 12'(i), 8'(8'h80 + i), 8'hFF);
            tick();
        end
        setA(1'b0, 1'b0, 12'h060, 8'h33, 8'hFF);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) setA(1'b0, 1'b1, 12'(i), 8'h00, 8'h00);
            else       setA(1'b1, 1'b1, 12'h000, 8'h00, 8'h00);
            tick();
            if (i < 4) begin
                chk($sformatf("strm_qA0_%0d", i), if0.qA, 8'(8'h80 + i));
                chk($sformatf("strm_vA0_%0d", i), if0.qA_valid, 1'b1);
            end else begin
                chk("strm_vA0_end", if0.qA_valid, 1'b0);
            end
            if (i >= 1) begin
                chk($sformatf("strm_qA1_%0d", i), if1.qA, 8'(8'h80 + i - 1));
                chk($sformatf("strm_vA1_%0d", i), if1.qA_valid, 1'b1);
            end else begin
                chk("strm_vA1_first", if1.qA_valid, 1'b0);
            end
        end
        tick();
        chk("strm_vA1_end", if1.qA_valid, 1'b0);
        chk("strm_qA1_hold", if1.qA, 8'h83);

        // Five more collision cycles: dut1 saturates at 3, dut0 reaches 7
        for (int k = 0; k < 5; k++) begin
            setA(1'b0, 1'b1, 12'h050, 8'h00, 8'h00);
            setB(1'b0, 1'b0, 12'h050, 8'h77, 8'hFF);
            tick();
        end
        idle_all();
        chk("sat_cnt1", cnt1, 2'd3);
        chk("sat_cnt0", cnt0, 8'd7);
        chk("sat_flag1", flag1, 1'b1);

        // Clear coincident with a collision
        setA(1'b0, 1'b1, 12'h050, 8'h00, 8'h00);
        setB(1'b0, 1'b0, 12'h050, 8'h78, 8'hFF);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        idle_all();
        chk("clr_cnt0", cnt0, 8'd0);
        chk("clr_flag0", flag0, 1'b0);
        chk("clr_cnt1", cnt1, 2'd0);
        chk("clr_flag1", flag1, 1'b0);

        // Asynchronous reset in the middle of a read stream
        setA(1'b0, 1'b1, 12'h000, 8'h00, 8'h00);
        tick();
        setA(1'b0, 1'b1, 12'h001, 8'h00, 8'h00);
        tick();
        chk("pre_rst_qA0", if0.qA, 8'h81);
        chk("pre_rst_qA1", if1.qA, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_qA0", if0.qA, 8'h00);
        chk("mid_rst_vA0", if0.qA_valid, 1'b0);
        chk("mid_rst_qA1", if1.qA, 8'h00);
        chk("mid_rst_vA1", if1.qA_valid, 1'b0);
        chk("mid_rst_qB0", if0.qB, 8'h00);

        // A write sampled on the release edge must not land
        setA(1'b0, 1'b0, 12'h060, 8'h99, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_vA1", if1.qA_valid, 1'b0);
        idle_all();
        tick();
        setA(1'b0, 1'b1, 12'h060, 8'h00, 8'h00);
        tick();
        chk("rel_wr_ign_qA0", if0.qA, 8'h33);
        idle_all();
        tick();
        chk("rel_wr_ign_qA1", if1.qA, 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
